// File: rtl/nic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nic_pkg
// Brief    : Shared constants for the NIC: PE register map and default widths.
// Revision : 1.0 - initial release
// ============================================================================
package nic_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_VC_BIT = 63;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        ADDR_IN_BUF   = 2'b00,
        ADDR_IN_STAT  = 2'b01,
        ADDR_OUT_BUF  = 2'b10,
        ADDR_OUT_STAT = 2'b11
    } nic_addr_e;

endpackage
`default_nettype wire

// File: rtl/nic_chan_buf.sv
`default_nettype none
// ============================================================================
// Module   : nic_chan_buf
// Brief    : One-entry packet buffer with full flag; load wins over clear.
// Revision : 1.0 - initial release
// ============================================================================
module nic_chan_buf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/nic.sv
`default_nettype none
// ============================================================================
// Module   : nic
// Brief    : PE <-> router network interface with one packet buffer per
//            direction. Define NIC_DROP_CNT_EN to add a dropped-write counter.
// Revision : 1.0 - initial release
// ============================================================================
module nic
    import nic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int VC_BIT = DEF_VC_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_in_load;
    logic                  w_in_clear;
    logic                  w_in_full;
    logic [DATA_W-1:0]     w_in_data;
    logic                  w_out_load;
    logic                  w_out_full;
    logic [DATA_W-1:0]     w_out_data;
    logic [DROP_CNT_W-1:0] w_drop_cnt;
    logic [DATA_W-1:0]     w_out_stat;
    logic [DATA_W-1:0]     r_d_out;

    assign w_rd = nicEn & ~nicWrEn;
    assign w_wr = nicEn & nicWrEn;

    assign w_in_load  = net_si & ~w_in_full;
    assign w_in_clear = w_rd & (addr == ADDR_IN_BUF) & w_in_full;
    assign w_out_load = w_wr & (addr == ADDR_OUT_BUF) & ~w_out_full;

    // Gated by reset so a buffered packet cannot leave in the reset cycle.
    assign net_so = ~reset & w_out_full & net_ro & (w_out_data[VC_BIT] == net_polarity);
    assign net_ri = ~w_in_full;
    assign net_do = w_out_data;

    nic_chan_buf #(.WIDTH(DATA_W)) u_in_buf (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_in_load),
        .i_data  (net_di),
        .i_clear (w_in_clear),
        .o_data  (w_in_data),
        .o_full  (w_in_full)
    );

    nic_chan_buf #(.WIDTH(DATA_W)) u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_out_load),
        .i_data  (d_in),
        .i_clear (net_so),
        .o_data  (w_out_data),
        .o_full  (w_out_full)
    );

`ifdef NIC_DROP_CNT_EN
    logic                  w_drop_event;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    assign w_drop_event = w_wr & (addr == ADDR_OUT_BUF) & w_out_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop_event && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign w_drop_cnt = r_drop_cnt;
`else
    assign w_drop_cnt = '0;
`endif

    always_comb begin
        w_out_stat                  = '0;
        w_out_stat[0]               = w_out_full;
        w_out_stat[16+:DROP_CNT_W]  = w_drop_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_out <= '0;
        end else if (w_rd) begin
            case (addr)
                ADDR_IN_BUF:   r_d_out <= w_in_data;
                ADDR_IN_STAT:  r_d_out <= DATA_W'(w_in_full);
                ADDR_OUT_STAT: r_d_out <= w_out_stat;
                default:       r_d_out <= r_d_out;
            endcase
        end
    end

    assign d_out = r_d_out;

endmodule
`default_nettype wire

// File: tb/tb_nic.sv
`default_nettype none
// ============================================================================
// Module   : tb_nic
// Brief    : Scoreboard bench for nic: queued PE reads and injections.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nic;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'b00;
    logic [63:0] d_in = '0;
    logic [63:0] d_out;
    logic        nicEn = 1'b0;
    logic        nicWrEn = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [63:0] net_di = '0;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [63:0] net_do;
    logic        net_polarity = 1'b0;

    logic [63:0] rd_q[$];
    logic [63:0] inj_q[$];
    logic        rd_seen = 1'b0;
    logic [63:0] e;
    int          checks = 0;
    int          errors = 0;

`ifdef NIC_DROP_CNT_EN
    localparam logic [63:0] EXP_STAT_DROP = 64'h0000_0000_0003_0001;
`else
    localparam logic [63:0] EXP_STAT_DROP = 64'h0000_0000_0000_0001;
`endif

    nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) net_polarity <= 1'b0;
        else       net_polarity <= ~net_polarity;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: reads show up on d_out one edge after being sampled.
    always @(posedge clk) rd_seen <= nicEn && !nicWrEn && !reset && (addr != 2'b10);

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
            else                  chk("rd_data", d_out, rd_q.pop_front());
        end
        if (net_so) begin
            if (inj_q.size() == 0) begin
                chk("inj_unexpected", 64'd1, 64'd0);
            end else begin
                e = inj_q.pop_front();
                chk("inj_data", net_do, e);
                chk("inj_vc", {63'b0, net_polarity}, {63'b0, e[63]});
                chk("inj_ro", {63'b0, net_ro}, 64'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pe_read(input logic [1:0] a, input logic [63:0] exp);
        rd_q.push_back(exp);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        tick();
        nicEn = 1'b0;
    endtask

    task automatic pe_write(input logic [1:0] a, input logic [63:0] data, input bit accepted);
        if (accepted) inj_q.push_back(data);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = data;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic wait_inj(input string name, input int limit);
        int n = 0;
        while (inj_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk(name, 64'(inj_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst_ri", {63'b0, net_ri}, 64'd1);
        chk("rst_so", {63'b0, net_so}, 64'd0);
        chk("rst_dout", d_out, 64'd0);
        pe_read(2'b01, 64'd0);
        pe_read(2'b11, 64'd0);

        // VC=1 packet leaves only in a polarity-1 cycle
        net_ro = 1'b1;
        pe_write(2'b10, 64'h8000_0000_0000_00AA, 1'b1);
        wait_inj("inj_vc1_timeout", 4);
        pe_read(2'b11, 64'd0);

        // VC=0 packet held while the router is not ready
        net_ro = 1'b0;
        pe_write(2'b10, 64'h0000_0000_0000_0055, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("so_held", {63'b0, net_so}, 64'd0);
            tick();
        end
        net_ro = 1'b1;
        wait_inj("inj_vc0_timeout", 2);
        pe_read(2'b11, 64'd0);

        // Ejection, then a second packet while full is ignored
        net_si = 1'b1; net_di = 64'h0000_0000_0000_1234;
        tick();
        net_si = 1'b0;
        chk("ri_full", {63'b0, net_ri}, 64'd0);
        pe_read(2'b01, 64'd1);
        net_si = 1'b1; net_di = 64'h0000_0000_0000_5678;
        tick();
        net_si = 1'b0;
        chk("ri_still_full", {63'b0, net_ri}, 64'd0);
        pe_read(2'b00, 64'h0000_0000_0000_1234);
        chk("ri_freed", {63'b0, net_ri}, 64'd1);
        pe_read(2'b01, 64'd0);
        pe_read(2'b00, 64'h0000_0000_0000_1234);
        pe_read(2'b01, 64'd0);

        // Dropped writes while the injection buffer is full
        net_ro = 1'b0;
        pe_write(2'b10, 64'h0000_0000_0000_00A1, 1'b1);
        pe_write(2'b10, 64'h0000_0000_0000_00B2, 1'b0);
        pe_write(2'b10, 64'h0000_0000_0000_00C3, 1'b0);
        pe_write(2'b10, 64'h0000_0000_0000_00D4, 1'b0);
        pe_read(2'b11, EXP_STAT_DROP);
        chk("keep_first", net_do, 64'h0000_0000_0000_00A1);
        pe_write(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        pe_read(2'b00, 64'h0000_0000_0000_1234);

        // Reset with both buffers full
        net_si = 1'b1; net_di = 64'h0000_0000_0000_0099;
        tick();
        net_si = 1'b0;
        chk("ri_before_rst", {63'b0, net_ri}, 64'd0);
        reset = 1'b1; net_ro = 1'b1;
        inj_q.delete();
        tick();
        reset = 1'b0;
        chk("post_rst_ri", {63'b0, net_ri}, 64'd1);
        chk("post_rst_so", {63'b0, net_so}, 64'd0);
        chk("post_rst_dout", d_out, 64'd0);
        chk("post_rst_do", net_do, 64'd0);
        pe_read(2'b01, 64'd0);
        pe_read(2'b11, 64'd0);
        tick();

        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("inj_q_empty", 64'(inj_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
